// File: rtl/btn_ctrl_pkg.sv
// Shared types and constants for the button gesture / LED controller.
package btn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT2     = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HOLD = 3'd4
  } gesture_t;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STEADY = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic [2:0] CHASE_RST = 3'b001;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a tick-based debounce counter.
module btn_debounce #(
  parameter int DEBOUNCE_MS = 20,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic btn_db
);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  // Count ticks of disagreement; flip the debounced level once it has lasted long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      btn_db <= 1'b0;
    end else if (sync_b == btn_db) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == CNT_W'(DEBOUNCE_MS - 1)) begin
        btn_db <= sync_b;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_gesture_led_ctrl.sv
// Single-button gesture classifier (single/double/long) driving a 3-LED mode sequencer.
module btn_gesture_led_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_MS   = 20,
  parameter int DBL_WINDOW_MS = 400,
  parameter int LONG_MS       = 1000,
  parameter int STEP_MS       = 250,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn,
  output logic [2:0] led,
  output logic [1:0] mode,
  output logic       evt_single,
  output logic       evt_double,
  output logic       evt_long
);

  // After reset the button is only trusted once it has been seen low for
  // longer than a full debounce interval, or once a debounced release occurs.
  // This keeps a button held through reset from registering as a new press.
  localparam int ARM_TICKS = DEBOUNCE_MS + 4;

  logic             btn_db;
  logic             btn_db_q;
  logic             rise;
  logic             fall;
  logic             armed;
  logic             arm_hit;
  logic             long_hit;
  logic             win_hit;
  gesture_t         state;
  gesture_t         state_nxt;
  logic [CNT_W-1:0] timer;
  logic             single_nxt;
  logic             double_nxt;
  logic             long_nxt;
  logic             freeze;
  logic             freeze_nxt;
  logic [1:0]       mode_nxt;
  logic [CNT_W-1:0] step_cnt;
  logic [2:0]       chase;
  logic             blink_on;

  btn_debounce #(
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .CNT_W      (CNT_W)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .btn   (btn),
    .btn_db(btn_db)
  );

  assign rise     = btn_db & ~btn_db_q;
  assign fall     = ~btn_db & btn_db_q;
  assign long_hit = tick && (timer == CNT_W'(LONG_MS - 1));
  assign win_hit  = tick && (timer == CNT_W'(DBL_WINDOW_MS - 1));
  assign arm_hit  = (state == ST_IDLE) && !btn_db && tick && (timer == CNT_W'(ARM_TICKS - 1));

  // Gesture state, state timer, edge history, arming flag and registered event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      timer      <= '0;
      btn_db_q   <= 1'b0;
      armed      <= 1'b0;
      evt_single <= 1'b0;
      evt_double <= 1'b0;
      evt_long   <= 1'b0;
    end else begin
      state    <= state_nxt;
      btn_db_q <= btn_db;
      if (state_nxt != state) begin
        timer <= '0;
      end else if (tick && (timer != '1)) begin
        timer <= timer + CNT_W'(1);
      end
      if (fall || arm_hit) begin
        armed <= 1'b1;
      end
      evt_single <= single_nxt;
      evt_double <= double_nxt;
      evt_long   <= long_nxt;
    end
  end

  // Next gesture state; debounced edges take priority over timer expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (rise && armed) state_nxt = ST_PRESS1;
      ST_PRESS1: begin
        if (fall)          state_nxt = ST_WAIT2;
        else if (long_hit) state_nxt = ST_LONG_HOLD;
      end
      ST_WAIT2: begin
        if (rise)         state_nxt = ST_PRESS2;
        else if (win_hit) state_nxt = ST_IDLE;
      end
      ST_PRESS2:    if (fall) state_nxt = ST_IDLE;
      ST_LONG_HOLD: if (fall) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Gesture classification, registered into one-clk event pulses.
  always_comb begin
    single_nxt = (state == ST_WAIT2) && !rise && win_hit;
    double_nxt = (state == ST_PRESS2) && fall;
    long_nxt   = (state == ST_PRESS1) && !fall && long_hit;
  end

  // Mode/freeze response to the event pulses.
  always_comb begin
    mode_nxt   = mode;
    freeze_nxt = freeze;
    if (evt_long) begin
      mode_nxt   = MODE_OFF;
      freeze_nxt = 1'b0;
    end else if (evt_single) begin
      mode_nxt = mode + 2'd1;
    end else if (evt_double) begin
      freeze_nxt = ~freeze;
    end
  end

  // Mode register and animation state; a mode change restarts the animation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode     <= MODE_OFF;
      freeze   <= 1'b0;
      step_cnt <= '0;
      chase    <= CHASE_RST;
      blink_on <= 1'b1;
    end else begin
      mode   <= mode_nxt;
      freeze <= freeze_nxt;
      if (mode_nxt != mode) begin
        step_cnt <= '0;
        chase    <= CHASE_RST;
        blink_on <= 1'b1;
      end else if (!freeze && tick) begin
        if (step_cnt == CNT_W'(STEP_MS - 1)) begin
          step_cnt <= '0;
          chase    <= {chase[1:0], chase[2]};
          blink_on <= ~blink_on;
        end else begin
          step_cnt <= step_cnt + CNT_W'(1);
        end
      end
    end
  end

  // LED drive derived from the current mode and animation state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= 3'b000;
    end else begin
      case (mode)
        MODE_OFF:    led <= 3'b000;
        MODE_STEADY: led <= 3'b111;
        MODE_CHASE:  led <= chase;
        default:     led <= {3{blink_on}};
      endcase
    end
  end

endmodule

// File: tb/tb_btn_gesture_led_ctrl.sv
// Directed testbench for btn_gesture_led_ctrl with a 1-in-4 clk tick strobe.
module tb_btn_gesture_led_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       btn;
  logic [2:0] led;
  logic [1:0] mode;
  logic       evt_single;
  logic       evt_double;
  logic       evt_long;

  int n_vec = 0;
  int n_err = 0;
  int tick_cnt = 0;
  int n_single = 0, n_double = 0, n_long = 0;
  int t_single = 0, t_double = 0, t_long = 0;
  int onehot_err = 0, width_err = 0;
  logic p_s = 1'b0, p_d = 1'b0, p_l = 1'b0;

  btn_gesture_led_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .btn       (btn),
    .led       (led),
    .mode      (mode),
    .evt_single(evt_single),
    .evt_double(evt_double),
    .evt_long  (evt_long)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  always @(posedge clk) if (tick === 1'b1) tick_cnt <= tick_cnt + 1;

  always @(negedge clk) begin
    if (evt_single === 1'b1) begin n_single++; t_single = tick_cnt; end
    if (evt_double === 1'b1) begin n_double++; t_double = tick_cnt; end
    if (evt_long === 1'b1)   begin n_long++;   t_long   = tick_cnt; end
    if ($countones({evt_single, evt_double, evt_long}) > 1) onehot_err++;
    if ((evt_single && p_s) || (evt_double && p_d) || (evt_long && p_l)) width_err++;
    p_s = evt_single;
    p_d = evt_double;
    p_l = evt_long;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1);
  end

  function automatic int cnt_of(input int kind);
    case (kind)
      0:       return n_single;
      1:       return n_double;
      default: return n_long;
    endcase
  endfunction

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic press(input int hold);
    @(negedge clk);
    btn = 1'b1;
    wait_ticks(hold);
    btn = 1'b0;
  endtask

  task automatic wait_evt(input int kind, input int budget, output bit got);
    int base;
    base = cnt_of(kind);
    got  = 1'b0;
    for (int i = 0; i < budget * 4 && !got; i++) begin
      @(posedge clk);
      if (cnt_of(kind) != base) got = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_single(output bit got);
    press(50);
    wait_evt(0, 600, got);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    n_vec++;
    if (led !== 3'b000) begin n_err++; $display("FAIL reset_led: got %b expected 000", led); end
    n_vec++;
    if (mode !== 2'd0) begin n_err++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    n_vec++;
    if ({evt_single, evt_double, evt_long} !== 3'b000) begin
      n_err++; $display("FAIL reset_evt: got %b expected 000", {evt_single, evt_double, evt_long});
    end
  endtask

  task automatic test_single();
    int t_rel, b_s, b_d, b_l;
    b_s = n_single; b_d = n_double; b_l = n_long;
    press(50);
    t_rel = tick_cnt;
    wait_ticks(500);
    n_vec++;
    if (n_single - b_s != 1) begin n_err++; $display("FAIL single_count: got %0d expected 1", n_single - b_s); end
    n_vec++;
    if ((n_double - b_d) + (n_long - b_l) != 0) begin
      n_err++; $display("FAIL single_other_evt: got %0d expected 0", (n_double - b_d) + (n_long - b_l));
    end
    n_vec++;
    if (t_single - t_rel < 419 || t_single - t_rel > 422) begin
      n_err++; $display("FAIL single_latency: got %0d ticks expected 419..422", t_single - t_rel);
    end
    n_vec++;
    if (mode !== 2'd1) begin n_err++; $display("FAIL single_mode: got %0d expected 1", mode); end
    n_vec++;
    if (led !== 3'b111) begin n_err++; $display("FAIL single_led: got %b expected 111", led); end
  endtask

  task automatic test_mode_cycle();
    bit got;
    do_single(got);
    n_vec++;
    if (!got || mode !== 2'd2) begin n_err++; $display("FAIL cycle_m2: got %0d (evt %0d) expected 2", mode, got); end
    n_vec++;
    if (led !== 3'b001) begin n_err++; $display("FAIL chase_start: got %b expected 001", led); end
    wait_ticks(125);
    n_vec++;
    if (led !== 3'b001) begin n_err++; $display("FAIL chase_0: got %b expected 001", led); end
    wait_ticks(250);
    n_vec++;
    if (led !== 3'b010) begin n_err++; $display("FAIL chase_1: got %b expected 010", led); end
    wait_ticks(250);
    n_vec++;
    if (led !== 3'b100) begin n_err++; $display("FAIL chase_2: got %b expected 100", led); end
    wait_ticks(250);
    n_vec++;
    if (led !== 3'b001) begin n_err++; $display("FAIL chase_3: got %b expected 001", led); end
    do_single(got);
    n_vec++;
    if (!got || mode !== 2'd3) begin n_err++; $display("FAIL cycle_m3: got %0d (evt %0d) expected 3", mode, got); end
    wait_ticks(125);
    n_vec++;
    if (led !== 3'b111) begin n_err++; $display("FAIL blink_on: got %b expected 111", led); end
    wait_ticks(250);
    n_vec++;
    if (led !== 3'b000) begin n_err++; $display("FAIL blink_off: got %b expected 000", led); end
    do_single(got);
    n_vec++;
    if (!got || mode !== 2'd0 || led !== 3'b000) begin
      n_err++; $display("FAIL cycle_m0: got mode %0d led %b expected 0 000", mode, led);
    end
  endtask

  task automatic test_double();
    bit got, got2;
    int b_s;
    do_single(got);
    do_single(got2);
    n_vec++;
    if (!got || !got2 || mode !== 2'd2) begin n_err++; $display("FAIL dbl_setup_mode: got %0d expected 2", mode); end
    wait_ticks(100);
    b_s = n_single;
    press(50);
    wait_ticks(100);
    press(50);
    wait_evt(1, 600, got);
    repeat (2) @(negedge clk);
    n_vec++;
    if (!got) begin n_err++; $display("FAIL dbl_evt: got no evt_double expected one"); end
    n_vec++;
    if (led !== 3'b010) begin n_err++; $display("FAIL dbl_freeze_led: got %b expected 010", led); end
    wait_ticks(1000);
    n_vec++;
    if (led !== 3'b010 || mode !== 2'd2) begin
      n_err++; $display("FAIL dbl_hold: got led %b mode %0d expected 010 2", led, mode);
    end
    press(50);
    wait_ticks(100);
    press(50);
    wait_evt(1, 600, got);
    wait_ticks(300);
    n_vec++;
    if (!got || led !== 3'b100) begin n_err++; $display("FAIL dbl_unfreeze: got %b (evt %0d) expected 100", led, got); end
    n_vec++;
    if (n_single != b_s) begin n_err++; $display("FAIL dbl_no_single: got %0d expected 0", n_single - b_s); end
  endtask

  task automatic test_long();
    bit got;
    int t_press, b_s, b_d, b_l;
    do_single(got);
    n_vec++;
    if (!got || mode !== 2'd3) begin n_err++; $display("FAIL long_setup_mode: got %0d expected 3", mode); end
    b_s = n_single; b_d = n_double; b_l = n_long;
    @(negedge clk);
    btn = 1'b1;
    t_press = tick_cnt;
    wait_evt(2, 1100, got);
    n_vec++;
    if (!got || t_long - t_press < 1019 || t_long - t_press > 1022) begin
      n_err++; $display("FAIL long_latency: got %0d ticks (evt %0d) expected 1019..1022", t_long - t_press, got);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (mode !== 2'd0 || led !== 3'b000) begin
      n_err++; $display("FAIL long_mode: got mode %0d led %b expected 0 000", mode, led);
    end
    wait_ticks(1500 - (tick_cnt - t_press));
    btn = 1'b0;
    wait_ticks(500);
    n_vec++;
    if (n_long - b_l != 1 || n_single != b_s || n_double != b_d) begin
      n_err++; $display("FAIL long_release: got s%0d d%0d l%0d expected s0 d0 l1",
                        n_single - b_s, n_double - b_d, n_long - b_l);
    end
  endtask

  task automatic test_glitch();
    int b_s, b_d, b_l;
    b_s = n_single; b_d = n_double; b_l = n_long;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      btn = 1'b1;
      wait_ticks(5);
      btn = 1'b0;
      wait_ticks(25);
    end
    wait_ticks(450);
    n_vec++;
    if (n_single != b_s || n_double != b_d || n_long != b_l) begin
      n_err++; $display("FAIL glitch_evt: got s%0d d%0d l%0d expected none",
                        n_single - b_s, n_double - b_d, n_long - b_l);
    end
    n_vec++;
    if (mode !== 2'd0 || led !== 3'b000) begin
      n_err++; $display("FAIL glitch_state: got mode %0d led %b expected 0 000", mode, led);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    int b_s, b_d, b_l;
    do_single(got);
    n_vec++;
    if (!got || mode !== 2'd1 || led !== 3'b111) begin
      n_err++; $display("FAIL rstmid_setup: got mode %0d led %b expected 1 111", mode, led);
    end
    b_s = n_single; b_d = n_double; b_l = n_long;
    press(50);
    wait_ticks(100);
    @(negedge clk);
    btn = 1'b1;
    wait_ticks(60);
    rst = 1'b1;
    #1;
    n_vec++;
    if (led !== 3'b000 || mode !== 2'd0 || {evt_single, evt_double, evt_long} !== 3'b000) begin
      n_err++; $display("FAIL rstmid_outputs: got led %b mode %0d evt %b expected 000 0 000",
                        led, mode, {evt_single, evt_double, evt_long});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ticks(50);
    btn = 1'b0;
    wait_ticks(500);
    n_vec++;
    if (n_single != b_s || n_double != b_d || n_long != b_l || mode !== 2'd0) begin
      n_err++; $display("FAIL rstmid_noevt: got s%0d d%0d l%0d mode %0d expected none 0",
                        n_single - b_s, n_double - b_d, n_long - b_l, mode);
    end
    do_single(got);
    n_vec++;
    if (!got || mode !== 2'd1 || led !== 3'b111) begin
      n_err++; $display("FAIL rstmid_rearm: got mode %0d led %b (evt %0d) expected 1 111", mode, led, got);
    end
  endtask

  task automatic test_pulse_rules();
    n_vec++;
    if (onehot_err != 0) begin n_err++; $display("FAIL evt_onehot: got %0d overlaps expected 0", onehot_err); end
    n_vec++;
    if (width_err != 0) begin n_err++; $display("FAIL evt_width: got %0d wide pulses expected 0", width_err); end
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    repeat (4) @(negedge clk);
    test_reset();
    rst = 1'b0;
    wait_ticks(40);
    test_single();
    test_mode_cycle();
    test_double();
    test_long();
    test_glitch();
    test_reset_mid();
    test_pulse_rules();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
